// File: rtl/store_align_unit.sv
// Store-path aligner: byte-lane masks, lane-shifted write data,
// valid/ready handshake and two-beat split of word-crossing stores.
module store_align_unit #(
  parameter int DATA_W         = 32,
  parameter int ADDR_W         = 32,
  parameter int SPLIT_MISALIGN = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [ADDR_W-1:0]     req_addr,
  input  logic [DATA_W-1:0]     req_data,
  input  logic [1:0]            req_size,
  output logic                  mem_valid,
  input  logic                  mem_ready,
  output logic [ADDR_W-1:0]     mem_addr,
  output logic [DATA_W/8-1:0]   mem_mask,
  output logic [DATA_W-1:0]     mem_wdata,
  output logic                  misalign_err
);

  localparam int BYTES = DATA_W / 8;
  localparam int OFFW  = $clog2(BYTES);

  typedef enum logic [1:0] {
    IDLE,
    FIRST,
    LAST
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [ADDR_W-1:0]    r_addr;
  logic [BYTES-1:0]     r_mask;
  logic [DATA_W-1:0]    r_wdata;
  logic [ADDR_W-1:0]    r_b1_addr;
  logic [BYTES-1:0]     r_b1_mask;
  logic [DATA_W-1:0]    r_b1_wdata;
  logic                 r_err;

  logic                 w_accept;
  logic                 w_illegal;
  logic                 w_cross;
  logic                 w_load0;
  logic                 w_load1;
  logic [3:0]           w_n;
  logic [OFFW-1:0]      w_off;
  logic [ADDR_W-1:0]    w_base;
  logic [ADDR_W-1:0]    w_base1;
  logic [2*BYTES-1:0]   w_nmask;
  logic [2*BYTES-1:0]   w_m2;
  logic [DATA_W-1:0]    w_dsz;
  logic [2*DATA_W-1:0]  w_d2;

  assign req_ready = !rst &&
                     (r_state == IDLE ||
                      (r_state == LAST && mem_ready));
  assign w_accept  = req_valid && req_ready;

  assign w_n     = 4'd1 << req_size;
  assign w_off   = req_addr[OFFW-1:0];
  assign w_base  = {req_addr[ADDR_W-1:OFFW], {OFFW{1'b0}}};
  assign w_base1 = w_base + ADDR_W'(BYTES);

  // Size-wide byte mask and size-truncated data, before shifting into lanes
  always_comb begin
    w_nmask = '0;
    w_dsz   = '0;
    for (int i = 0; i < 2*BYTES; i++) begin
      w_nmask[i] = (i < int'(w_n));
    end
    for (int i = 0; i < BYTES; i++) begin
      w_dsz[8*i+:8] = w_nmask[i] ? req_data[8*i+:8] : 8'h00;
    end
  end

  assign w_m2    = w_nmask << w_off;
  assign w_d2    = {{DATA_W{1'b0}}, w_dsz} << {w_off, 3'b000};
  assign w_cross = |w_m2[2*BYTES-1:BYTES];

  assign w_illegal = (w_cross && SPLIT_MISALIGN == 0) ||
                     (req_size == 2'd3 && BYTES < 8);

  // Next state and beat-load selects; a legal accept overrides the drain
  always_comb begin
    w_next  = r_state;
    w_load0 = 1'b0;
    w_load1 = 1'b0;
    case (r_state)
      IDLE:  w_next = IDLE;
      FIRST: begin
        if (mem_ready) begin
          w_load1 = 1'b1;
          w_next  = LAST;
        end
      end
      LAST: begin
        if (mem_ready) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
    if (w_accept && !w_illegal) begin
      w_load0 = 1'b1;
      w_next  = w_cross ? FIRST : LAST;
    end
  end

  // State register; reset drops any pending second beat
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  // Output beat and pending second-beat registers, error pulse
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_addr     <= '0;
      r_mask     <= '0;
      r_wdata    <= '0;
      r_b1_addr  <= '0;
      r_b1_mask  <= '0;
      r_b1_wdata <= '0;
      r_err      <= 1'b0;
    end else begin
      r_err <= w_accept && w_illegal;
      if (w_load0) begin
        r_addr     <= w_base;
        r_mask     <= w_m2[BYTES-1:0];
        r_wdata    <= w_d2[DATA_W-1:0];
        r_b1_addr  <= w_base1;
        r_b1_mask  <= w_m2[2*BYTES-1:BYTES];
        r_b1_wdata <= w_d2[2*DATA_W-1:DATA_W];
      end else if (w_load1) begin
        r_addr  <= r_b1_addr;
        r_mask  <= r_b1_mask;
        r_wdata <= r_b1_wdata;
      end
    end
  end

  assign mem_valid    = (r_state != IDLE);
  assign mem_addr     = r_addr;
  assign mem_mask     = r_mask;
  assign mem_wdata    = r_wdata;
  assign misalign_err = r_err;

endmodule

// File: tb/tb_store_align_unit.sv
// Testbench for store_align_unit: 32-bit split, 32-bit reject and
// 64-bit split instances driven with directed vectors.
module tb_store_align_unit;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // instance A: DATA_W=32, SPLIT=1
  logic        a_rv = 0, a_rr, a_mv, a_mr = 1, a_err;
  logic [31:0] a_addr = 0, a_data = 0, a_maddr, a_wd;
  logic [1:0]  a_size = 0;
  logic [3:0]  a_mask;

  // instance B: DATA_W=32, SPLIT=0
  logic        b_rv = 0, b_rr, b_mv, b_mr = 1, b_err;
  logic [31:0] b_addr = 0, b_data = 0, b_maddr, b_wd;
  logic [1:0]  b_size = 0;
  logic [3:0]  b_mask;

  // instance C: DATA_W=64, SPLIT=1
  logic        c_rv = 0, c_rr, c_mv, c_mr = 1, c_err;
  logic [31:0] c_addr = 0, c_maddr;
  logic [63:0] c_data = 0, c_wd;
  logic [1:0]  c_size = 0;
  logic [7:0]  c_mask;

  store_align_unit #(.DATA_W(32), .ADDR_W(32), .SPLIT_MISALIGN(1)) u_a (
    .clk(clk), .rst(rst),
    .req_valid(a_rv), .req_ready(a_rr),
    .req_addr(a_addr), .req_data(a_data), .req_size(a_size),
    .mem_valid(a_mv), .mem_ready(a_mr),
    .mem_addr(a_maddr), .mem_mask(a_mask), .mem_wdata(a_wd),
    .misalign_err(a_err)
  );

  store_align_unit #(.DATA_W(32), .ADDR_W(32), .SPLIT_MISALIGN(0)) u_b (
    .clk(clk), .rst(rst),
    .req_valid(b_rv), .req_ready(b_rr),
    .req_addr(b_addr), .req_data(b_data), .req_size(b_size),
    .mem_valid(b_mv), .mem_ready(b_mr),
    .mem_addr(b_maddr), .mem_mask(b_mask), .mem_wdata(b_wd),
    .misalign_err(b_err)
  );

  store_align_unit #(.DATA_W(64), .ADDR_W(32), .SPLIT_MISALIGN(1)) u_c (
    .clk(clk), .rst(rst),
    .req_valid(c_rv), .req_ready(c_rr),
    .req_addr(c_addr), .req_data(c_data), .req_size(c_size),
    .mem_valid(c_mv), .mem_ready(c_mr),
    .mem_addr(c_maddr), .mem_mask(c_mask), .mem_wdata(c_wd),
    .misalign_err(c_err)
  );

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic [1:0]  size;
    int          nb;
    logic [31:0] a0;
    logic [3:0]  m0;
    logic [31:0] d0;
    logic [31:0] a1;
    logic [3:0]  m1;
    logic [31:0] d1;
  } vec_t;

  vec_t tbl [10];

  task automatic chk(input string name,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic a_send(input logic [31:0] ad,
                        input logic [31:0] dt,
                        input logic [1:0]  sz);
    int t;
    @(negedge clk);
    a_rv = 1; a_addr = ad; a_data = dt; a_size = sz;
    t = 0;
    while (!a_rr && t < 20) begin
      @(negedge clk);
      t++;
    end
    chk("a_req_ready", a_rr, 1);
    @(posedge clk);
    #1 a_rv = 0;
  endtask

  task automatic c_send(input logic [31:0] ad,
                        input logic [63:0] dt,
                        input logic [1:0]  sz);
    int t;
    @(negedge clk);
    c_rv = 1; c_addr = ad; c_data = dt; c_size = sz;
    t = 0;
    while (!c_rr && t < 20) begin
      @(negedge clk);
      t++;
    end
    chk("c_req_ready", c_rr, 1);
    @(posedge clk);
    #1 c_rv = 0;
  endtask

  task automatic a_beat(input string nm,
                        input logic [31:0] ea,
                        input logic [3:0]  em,
                        input logic [31:0] ed);
    chk({nm, "_valid"}, a_mv, 1);
    chk({nm, "_addr"}, a_maddr, ea);
    chk({nm, "_mask"}, a_mask, em);
    chk({nm, "_wdata"}, a_wd, ed);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{32'h103, 32'h000000AB, 2'd0, 1,
               32'h100, 4'h8, 32'hAB000000, 32'h0, 4'h0, 32'h0};
    tbl[1] = '{32'h100, 32'h123456CD, 2'd0, 1,
               32'h100, 4'h1, 32'h000000CD, 32'h0, 4'h0, 32'h0};
    tbl[2] = '{32'h102, 32'h0000BEEF, 2'd1, 1,
               32'h100, 4'hC, 32'hBEEF0000, 32'h0, 4'h0, 32'h0};
    tbl[3] = '{32'h101, 32'hFFFF1234, 2'd1, 1,
               32'h100, 4'h6, 32'h00123400, 32'h0, 4'h0, 32'h0};
    tbl[4] = '{32'h040, 32'hCAFEF00D, 2'd2, 1,
               32'h040, 4'hF, 32'hCAFEF00D, 32'h0, 4'h0, 32'h0};
    tbl[5] = '{32'h206, 32'h11223344, 2'd2, 2,
               32'h204, 4'hC, 32'h33440000,
               32'h208, 4'h3, 32'h00001122};
    tbl[6] = '{32'h107, 32'h0000A1B2, 2'd1, 2,
               32'h104, 4'h8, 32'hB2000000,
               32'h108, 4'h1, 32'h000000A1};
    tbl[7] = '{32'h305, 32'hAABBCCDD, 2'd2, 2,
               32'h304, 4'hE, 32'hBBCCDD00,
               32'h308, 4'h1, 32'h000000AA};
    tbl[8] = '{32'hFFFFFFFE, 32'h11223344, 2'd2, 2,
               32'hFFFFFFFC, 4'hC, 32'h33440000,
               32'h00000000, 4'h3, 32'h00001122};
    tbl[9] = '{32'h008, 32'h01020304, 2'd3, 0,
               32'h0, 4'h0, 32'h0, 32'h0, 4'h0, 32'h0};

    // reset state
    #12;
    chk("rst_req_ready", a_rr, 0);
    chk("rst_mem_valid", a_mv, 0);
    chk("rst_mem_mask", a_mask, 0);
    chk("rst_mem_addr", a_maddr, 0);
    chk("rst_mem_wdata", a_wd, 0);
    chk("rst_err", a_err, 0);
    @(negedge clk);
    rst = 0;

    // table vectors on instance A, memory always ready
    for (int k = 0; k < 10; k++) begin
      a_mr = 1;
      a_send(tbl[k].addr, tbl[k].data, tbl[k].size);
      @(negedge clk);
      if (tbl[k].nb == 0) begin
        chk("tbl_err", a_err, 1);
        chk("tbl_err_novalid", a_mv, 0);
        @(negedge clk);
        chk("tbl_err_pulse", a_err, 0);
      end else begin
        a_beat("tbl_b0", tbl[k].a0, tbl[k].m0, tbl[k].d0);
        if (tbl[k].nb == 2) begin
          @(negedge clk);
          a_beat("tbl_b1", tbl[k].a1, tbl[k].m1, tbl[k].d1);
        end
      end
    end

    // stall on beat0 of a split store, then back-to-back reload
    @(negedge clk);
    a_mr = 0;
    a_rv = 1; a_addr = 32'h206; a_data = 32'h11223344; a_size = 2;
    chk("stall_idle_ready", a_rr, 1);
    @(posedge clk);
    #1 a_rv = 0;
    for (int s = 0; s < 5; s++) begin
      @(negedge clk);
      a_beat("stall_b0", 32'h204, 4'hC, 32'h33440000);
      chk("stall_ready_low", a_rr, 0);
    end
    a_mr = 1;
    a_rv = 1; a_addr = 32'h300; a_data = 32'hDEADBEEF; a_size = 2;
    @(posedge clk);
    @(negedge clk);
    a_beat("stall_b1", 32'h208, 4'h3, 32'h00001122);
    chk("stall_last_ready", a_rr, 1);
    @(posedge clk);
    #1 a_rv = 0;
    @(negedge clk);
    a_beat("nobubble", 32'h300, 4'hF, 32'hDEADBEEF);
    @(negedge clk);
    chk("drain_idle", a_mv, 0);

    // reset between beat0 handshake and beat1
    a_send(32'h206, 32'h11223344, 2);
    @(negedge clk);
    a_beat("rstmid_b0", 32'h204, 4'hC, 32'h33440000);
    @(posedge clk);
    #1 rst = 1;
    #1;
    chk("rstmid_valid", a_mv, 0);
    chk("rstmid_mask", a_mask, 0);
    @(negedge clk);
    rst = 0;
    for (int s = 0; s < 3; s++) begin
      @(negedge clk);
      chk("rstmid_nobeat1", a_mv, 0);
    end

    // instance B: rejected misaligned half, then immediate next request
    @(negedge clk);
    b_rv = 1; b_addr = 32'h3; b_data = 32'h5566; b_size = 1;
    chk("b_ready", b_rr, 1);
    @(posedge clk);
    #1;
    b_addr = 32'h103; b_data = 32'hAB; b_size = 0;
    @(negedge clk);
    chk("b_err", b_err, 1);
    chk("b_err_novalid", b_mv, 0);
    chk("b_ready_after_err", b_rr, 1);
    @(posedge clk);
    #1 b_rv = 0;
    @(negedge clk);
    chk("b_err_pulse", b_err, 0);
    chk("b_sb_valid", b_mv, 1);
    chk("b_sb_addr", b_maddr, 32'h100);
    chk("b_sb_mask", b_mask, 4'h8);
    chk("b_sb_wdata", b_wd, 32'hAB000000);
    b_rv = 1; b_addr = 32'h8; b_data = 32'h01020304; b_size = 3;
    chk("b_sd_ready", b_rr, 1);
    @(posedge clk);
    #1 b_rv = 0;
    @(negedge clk);
    chk("b_sd_err", b_err, 1);
    chk("b_sd_novalid", b_mv, 0);
    @(negedge clk);
    chk("b_sd_err_pulse", b_err, 0);

    // instance C: 64-bit bus
    c_send(32'h8, 64'h0102030405060708, 3);
    @(negedge clk);
    chk("c_sd_valid", c_mv, 1);
    chk("c_sd_addr", c_maddr, 32'h8);
    chk("c_sd_mask", c_mask, 8'hFF);
    chk("c_sd_wdata", c_wd, 64'h0102030405060708);
    c_send(32'hC, 64'h00000000CAFEF00D, 2);
    @(negedge clk);
    chk("c_sw_addr", c_maddr, 32'h8);
    chk("c_sw_mask", c_mask, 8'hF0);
    chk("c_sw_wdata", c_wd, 64'hCAFEF00D00000000);
    c_send(32'h7, 64'h000000000000A1B2, 1);
    @(negedge clk);
    chk("c_sh_b0_valid", c_mv, 1);
    chk("c_sh_b0_addr", c_maddr, 32'h0);
    chk("c_sh_b0_mask", c_mask, 8'h80);
    chk("c_sh_b0_wdata", c_wd, 64'hB200000000000000);
    @(negedge clk);
    chk("c_sh_b1_valid", c_mv, 1);
    chk("c_sh_b1_addr", c_maddr, 32'h8);
    chk("c_sh_b1_mask", c_mask, 8'h01);
    chk("c_sh_b1_wdata", c_wd, 64'h00000000000000A1);
    chk("c_no_err", c_err, 0);
    @(negedge clk);
    chk("c_idle", c_mv, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
